// File: rtl/shift_add_datapath.sv
// Sequential unsigned shift-and-add multiplier datapath driven by the
// controller's reset/load/enable strobes; one partial-product step per enable.
module shift_add_datapath #(
   parameter int WIDTH = 8
) (
   input  logic               clock,
   input  logic               resetn,
   input  logic               reset,
   input  logic               load,
   input  logic               enable,
   input  logic [WIDTH-1:0]   a_in,
   input  logic [WIDTH-1:0]   b_in,
   output logic [2*WIDTH-1:0] product,
   output logic               done
);

   localparam int CNT_W = $clog2(WIDTH) + 1;
   localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(WIDTH);
   localparam logic [CNT_W-1:0] LAST_STEP  = CNT_W'(WIDTH - 1);

   typedef enum logic [1:0] {
      PH_IDLE,
      PH_RUN,
      PH_DONE
   } phase_t;

   logic [WIDTH-1:0]   a_reg, a_next;
   logic [WIDTH-1:0]   b_reg, b_next;
   logic [2*WIDTH-1:0] product_reg, product_next;
   logic [CNT_W-1:0]   count_reg, count_next;
   logic               done_reg, done_next;
   phase_t             phase;

   // Table of gated partial products; step i only ever adds entry i.
   logic [2*WIDTH-1:0] pp [WIDTH];

   generate
      for (genvar gi = 0; gi < WIDTH; gi++) begin : g_pp
         assign pp[gi] = b_reg[gi] ? ({{WIDTH{1'b0}}, a_reg} << gi) : '0;
      end
   endgenerate

   always_comb begin
      if (count_reg == LAST_COUNT)
         phase = PH_DONE;
      else if (count_reg == '0)
         phase = PH_IDLE;
      else
         phase = PH_RUN;
   end

   always_comb begin
      a_next       = a_reg;
      b_next       = b_reg;
      product_next = product_reg;
      count_next   = count_reg;
      done_next    = done_reg;
      if (reset || load) begin
         // A load always restarts from step 0 and never steps in the same cycle.
         product_next = '0;
         count_next   = '0;
         done_next    = 1'b0;
         if (load) begin
            a_next = a_in;
            b_next = b_in;
         end
      end else if (enable && (phase != PH_DONE)) begin
         product_next = product_reg + pp[count_reg[IDX_W-1:0]];
         count_next   = count_reg + CNT_W'(1);
         done_next    = (count_reg == LAST_STEP);
      end
   end

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         a_reg       <= '0;
         b_reg       <= '0;
         product_reg <= '0;
         count_reg   <= '0;
         done_reg    <= 1'b0;
      end else begin
         a_reg       <= a_next;
         b_reg       <= b_next;
         product_reg <= product_next;
         count_reg   <= count_next;
         done_reg    <= done_next;
      end
   end

   assign product = product_reg;
   assign done    = done_reg;

endmodule

// File: tb/tb_shift_add_datapath.sv
// Scoreboard bench for shift_add_datapath: stimulus queues expected
// product/done per cycle, a negedge monitor pops and compares.
module tb_shift_add_datapath;

   logic        clock = 1'b0;
   logic        resetn = 1'b0;
   logic        reset = 1'b0;
   logic        load = 1'b0;
   logic        enable = 1'b0;
   logic [7:0]  a_in = '0;
   logic [7:0]  b_in = '0;
   logic [15:0] product;
   logic        done;

   shift_add_datapath #(.WIDTH(8)) dut (
      .clock   (clock),
      .resetn  (resetn),
      .reset   (reset),
      .load    (load),
      .enable  (enable),
      .a_in    (a_in),
      .b_in    (b_in),
      .product (product),
      .done    (done)
   );

   always #5 clock = ~clock;

   typedef struct {
      int          cyc;
      logic [15:0] prod;
      logic        dn;
      string       name;
   } exp_t;

   exp_t sb_q[$];
   int   cycle_cnt = 0;
   int   n_checks = 0;
   int   n_fail = 0;

   always @(posedge clock) cycle_cnt <= cycle_cnt + 1;

   // Monitor: compares the entry queued for the current cycle.
   always @(negedge clock) begin
      exp_t e;
      while (sb_q.size() > 0 && sb_q[0].cyc < cycle_cnt) begin
         e = sb_q.pop_front();
         n_checks++;
         n_fail++;
         $display("FAIL %s: cycle %0d never sampled, product=%0d done=%0b required", e.name, e.cyc, e.prod, e.dn);
      end
      if (sb_q.size() > 0 && sb_q[0].cyc == cycle_cnt) begin
         e = sb_q.pop_front();
         n_checks++;
         if (product !== e.prod || done !== e.dn) begin
            n_fail++;
            $display("FAIL %s: cycle %0d got product=%0d done=%0b, required product=%0d done=%0b",
                     e.name, cycle_cnt, product, done, e.prod, e.dn);
         end else begin
            $display("ok   %s: cycle %0d product=%0d done=%0b", e.name, cycle_cnt, product, done);
         end
      end
   end

   task automatic expect_now(input string nm, input logic [15:0] p, input logic d);
      exp_t e;
      e.cyc  = cycle_cnt;
      e.prod = p;
      e.dn   = d;
      e.name = nm;
      sb_q.push_back(e);
   endtask

   task automatic cyc(input logic r, input logic l, input logic en,
                      input logic [7:0] a, input logic [7:0] b);
      reset  = r;
      load   = l;
      enable = en;
      a_in   = a;
      b_in   = b;
      @(posedge clock);
      #1;
   endtask

   // Invariant after k steps: a * (b mod 2^k).
   function automatic logic [15:0] partial(input logic [7:0] a, input logic [7:0] b, input int k);
      logic [15:0] m;
      m = (k >= 8) ? 16'h00FF : ((16'd1 << k) - 16'd1);
      return {8'd0, a} * {8'd0, (b & m[7:0])};
   endfunction

   // Enabled steps; operand inputs are driven to junk to prove they are ignored.
   task automatic run_en(input string nm, input int n, input logic [7:0] a,
                         input logic [7:0] b, input int k0);
      for (int i = 0; i < n; i++) begin
         int k;
         cyc(1'b0, 1'b0, 1'b1, 8'hA5, 8'h5A);
         k = (k0 + i + 1 > 8) ? 8 : (k0 + i + 1);
         expect_now(nm, partial(a, b, k), (k == 8));
      end
   endtask

   initial begin
      // resetn dominates strobes
      for (int i = 0; i < 2; i++) begin
         cyc(1'b1, 1'b1, 1'b1, 8'd13, 8'd11);
         expect_now("in_resetn", 16'd0, 1'b0);
      end
      resetn = 1'b1;
      for (int i = 0; i < 5; i++) begin
         cyc(1'b0, 1'b0, 1'b0, 8'd0, 8'd0);
         expect_now("idle_after_reset", 16'd0, 1'b0);
      end

      // reset+load+enable: no step on the load edge
      cyc(1'b1, 1'b1, 1'b1, 8'd13, 8'd11);
      expect_now("rle_load_13x11", 16'd0, 1'b0);
      run_en("mul_13x11", 9, 8'd13, 8'd11, 0);
      cyc(1'b0, 1'b0, 1'b0, 8'd0, 8'd0);
      expect_now("hold_143", 16'd143, 1'b1);

      // max operands, extra enables absorbed
      cyc(1'b0, 1'b1, 1'b0, 8'd255, 8'd255);
      expect_now("load_255x255", 16'd0, 1'b0);
      run_en("mul_255x255", 8, 8'd255, 8'd255, 0);
      for (int i = 0; i < 4; i++) begin
         cyc(1'b0, 1'b0, 1'b1, 8'd0, 8'd0);
         expect_now("extra_en_65025", 16'd65025, 1'b1);
      end

      // gaps in enable
      cyc(1'b0, 1'b1, 1'b0, 8'd5, 8'b0000_1011);
      expect_now("load_5x11", 16'd0, 1'b0);
      run_en("mul_5x11_a", 3, 8'd5, 8'd11, 0);
      for (int i = 0; i < 5; i++) begin
         cyc(1'b0, 1'b0, 1'b0, 8'd0, 8'd0);
         expect_now("gap_hold_15", 16'd15, 1'b0);
      end
      run_en("mul_5x11_b", 5, 8'd5, 8'd11, 3);
      cyc(1'b0, 1'b0, 1'b0, 8'd0, 8'd0);
      expect_now("hold_55", 16'd55, 1'b1);

      // reset without load keeps operands
      cyc(1'b1, 1'b0, 1'b1, 8'd200, 8'd200);
      expect_now("reset_only", 16'd0, 1'b0);
      run_en("rerun_5x11", 8, 8'd5, 8'd11, 0);
      cyc(1'b0, 1'b0, 1'b0, 8'd0, 8'd0);
      expect_now("rerun_hold_55", 16'd55, 1'b1);

      // reload mid-run
      cyc(1'b0, 1'b1, 1'b0, 8'd7, 8'd200);
      expect_now("load_7x200", 16'd0, 1'b0);
      run_en("mul_7x200", 4, 8'd7, 8'd200, 0);
      cyc(1'b0, 1'b1, 1'b1, 8'd3, 8'd4);
      expect_now("reload_3x4", 16'd0, 1'b0);
      run_en("mul_3x4", 8, 8'd3, 8'd4, 0);
      cyc(1'b0, 1'b0, 1'b0, 8'd0, 8'd0);
      expect_now("hold_12", 16'd12, 1'b1);

      // asynchronous resetn pulse between edges
      cyc(1'b0, 1'b1, 1'b0, 8'd9, 8'd3);
      expect_now("load_9x3", 16'd0, 1'b0);
      run_en("mul_9x3", 1, 8'd9, 8'd3, 0);
      cyc(1'b0, 1'b0, 1'b1, 8'd0, 8'd0);
      #1 resetn = 1'b0;
      #1 expect_now("async_clear", 16'd0, 1'b0);
      @(negedge clock);
      #1 resetn = 1'b1;
      cyc(1'b0, 1'b1, 1'b0, 8'd0, 8'd99);
      expect_now("load_0x99", 16'd0, 1'b0);
      run_en("mul_0x99", 8, 8'd0, 8'd99, 0);

      for (int i = 0; i < 20 && sb_q.size() > 0; i++) @(negedge clock);
      if (sb_q.size() > 0) begin
         n_checks++;
         n_fail++;
         $display("FAIL drain: %0d expectations left, required 0", sb_q.size());
      end
      @(negedge clock);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
